// File: rtl/lifm_lowering_unit_pkg.sv
// lowering_pkg: shared types and helpers for the IFM lowering unit.
// Holds the FSM state encoding and small width/packing helpers.
package lowering_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GATHER,
    ST_DRAIN,
    ST_OUT
  } state_e;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int col_lsb(input int j, input int w);
    return j * w;
  endfunction

endpackage

// File: rtl/lifm_lowering_unit_if.sv
// lowering_if: IFM load stream and LIFM column stream.
// The unit side is the slave; the feeder/consumer side is the master.
interface lowering_if #(
  parameter int WORD_WIDTH = 8,
  parameter int STEP_RANGE = 128
);
  logic                             ifm_valid;
  logic [WORD_WIDTH-1:0]            ifm_data;
  logic                             ifm_ready;
  logic                             col_valid;
  logic                             col_ready;
  logic [WORD_WIDTH*STEP_RANGE-1:0] lifm_column;
  logic [WORD_WIDTH-1:0]            kidx;
  logic                             last_kidx;
  logic                             last_tile;

  modport slave (
    input  ifm_valid, ifm_data, col_ready,
    output ifm_ready, col_valid, lifm_column,
    output kidx, last_kidx, last_tile
  );

  modport master (
    output ifm_valid, ifm_data, col_ready,
    input  ifm_ready, col_valid, lifm_column,
    input  kidx, last_kidx, last_tile
  );
endinterface

// File: rtl/lifm_lowering_unit_buffer.sv
// ifm_buffer: single-port IFM plane store.
// One-cycle synchronous read; a write returns the new word.
module ifm_buffer #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 8,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write-first port: read data follows a same-address write.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
      rdata_o       <= wdata_i;
    end else begin
      rdata_o <= mem_q[addr_i];
    end
  end
endmodule

// File: rtl/lifm_lowering_unit.sv
// lifm_lowering_unit: buffers one IFM plane and streams im2col columns.
// Columns leave tile-major, kernel-index-minor.
module lifm_lowering_unit
  import lowering_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int STEP_RANGE = 128,
  parameter int IFM_DEPTH  = 1024,
  parameter int ADDR_WIDTH = addr_w(IFM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable_in,
  input  logic [WORD_WIDTH-1:0] if_width,
  input  logic [WORD_WIDTH-1:0] if_height,
  input  logic [WORD_WIDTH-1:0] ke_width,
  input  logic [WORD_WIDTH-1:0] ke_height,
  input  logic [WORD_WIDTH-1:0] of_width,
  input  logic [WORD_WIDTH-1:0] of_height,
  input  logic [WORD_WIDTH-1:0] stride,
  lowering_if.slave             bus,
  output logic                  done,
  output logic                  cfg_error
);
  localparam int W  = WORD_WIDTH;
  localparam int W2 = 2 * WORD_WIDTH;
  localparam int JW = addr_w(STEP_RANGE);
  localparam int CW = WORD_WIDTH * STEP_RANGE;
  localparam int LO = col_lsb(1, WORD_WIDTH);

  state_e        state_q, state_d;
  logic [W-1:0]  iw_q, fw_q, fh_q, ow_q, s_q;
  logic [W2-1:0] nwords_q, nout_q, wcnt_q;
  logic [W2-1:0] p_q, tp_q;
  logic [W-1:0]  ox_q, oy_q, tox_q, toy_q;
  logic [W-1:0]  kx_q, ky_q, kidx_q;
  logic [JW-1:0] j_q;
  logic          cap_q, zero_q, done_q, err_q;
  logic [CW-1:0] col_q;

  logic [W2-1:0]         cfg_words, cfg_nout;
  logic [W2-1:0]         row, addr;
  logic                  cfg_ok, load_hs, out_hs;
  logic                  last_k, last_t, last_j, rd_zero;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [W-1:0]          rdata, cap_word;

  assign cfg_words = W2'(if_width) * W2'(if_height);
  assign cfg_nout  = W2'(of_width) * W2'(of_height);
  assign cfg_ok    = (|if_width) && (|if_height) &&
                     (|ke_width) && (|ke_height) &&
                     (|of_width) && (|of_height) &&
                     (|stride) &&
                     (cfg_words <= W2'(IFM_DEPTH));

  assign load_hs = (state_q == ST_LOAD) && bus.ifm_valid;
  assign out_hs  = (state_q == ST_OUT) && bus.col_ready;
  assign last_k  = (kx_q == fw_q - 1'b1) &&
                   (ky_q == fh_q - 1'b1);
  assign last_t  = (nout_q - tp_q) <= W2'(STEP_RANGE);
  assign last_j  = (j_q == JW'(STEP_RANGE - 1));

  assign row  = W2'(oy_q) * W2'(s_q) + W2'(ky_q);
  assign addr = row * W2'(iw_q) +
                W2'(ox_q) * W2'(s_q) + W2'(kx_q);

  // Padding positions and out-of-plane taps read as zero.
  assign rd_zero  = (p_q >= nout_q) || (addr >= nwords_q);
  assign ram_addr = (state_q == ST_LOAD) ?
                    wcnt_q[ADDR_WIDTH-1:0] :
                    addr[ADDR_WIDTH-1:0];
  assign cap_word = zero_q ? '0 : rdata;

  ifm_buffer #(
    .DEPTH (IFM_DEPTH),
    .WIDTH (WORD_WIDTH),
    .AW    (ADDR_WIDTH)
  ) u_buf (
    .clk     (clk),
    .we_i    (load_hs),
    .addr_i  (ram_addr),
    .wdata_i (bus.ifm_data),
    .rdata_o (rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_in && cfg_ok) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (load_hs && (wcnt_q + 1'b1 == nwords_q))
          state_d = ST_GATHER;
      end
      ST_GATHER: begin
        if (last_j) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_OUT;
      ST_OUT: begin
        if (out_hs)
          state_d = (last_k && last_t) ? ST_IDLE : ST_GATHER;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Geometry, counters and column shift register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iw_q     <= '0;
      fw_q     <= '0;
      fh_q     <= '0;
      ow_q     <= '0;
      s_q      <= '0;
      nwords_q <= '0;
      nout_q   <= '0;
      wcnt_q   <= '0;
      p_q      <= '0;
      tp_q     <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      tox_q    <= '0;
      toy_q    <= '0;
      kx_q     <= '0;
      ky_q     <= '0;
      kidx_q   <= '0;
      j_q      <= '0;
      cap_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      col_q    <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cap_q  <= (state_q == ST_GATHER);
      zero_q <= rd_zero;
      if (cap_q) col_q <= {cap_word, col_q[CW-1:LO]};
      unique case (state_q)
        ST_IDLE: begin
          if (enable_in && cfg_ok) begin
            iw_q     <= if_width;
            fw_q     <= ke_width;
            fh_q     <= ke_height;
            ow_q     <= of_width;
            s_q      <= stride;
            nwords_q <= cfg_words;
            nout_q   <= cfg_nout;
            wcnt_q   <= '0;
            p_q      <= '0;
            tp_q     <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            tox_q    <= '0;
            toy_q    <= '0;
            kx_q     <= '0;
            ky_q     <= '0;
            kidx_q   <= '0;
            j_q      <= '0;
          end else if (enable_in) begin
            err_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_hs) wcnt_q <= wcnt_q + 1'b1;
        end
        ST_GATHER: begin
          j_q <= last_j ? '0 : j_q + 1'b1;
          p_q <= p_q + 1'b1;
          if (ox_q == ow_q - 1'b1) begin
            ox_q <= '0;
            oy_q <= oy_q + 1'b1;
          end else begin
            ox_q <= ox_q + 1'b1;
          end
        end
        ST_OUT: begin
          if (out_hs && !last_k) begin
            kidx_q <= kidx_q + 1'b1;
            if (kx_q == fw_q - 1'b1) begin
              kx_q <= '0;
              ky_q <= ky_q + 1'b1;
            end else begin
              kx_q <= kx_q + 1'b1;
            end
            ox_q <= tox_q;
            oy_q <= toy_q;
            p_q  <= tp_q;
          end else if (out_hs && !last_t) begin
            kidx_q <= '0;
            kx_q   <= '0;
            ky_q   <= '0;
            tox_q  <= ox_q;
            toy_q  <= oy_q;
            tp_q   <= p_q;
          end else if (out_hs) begin
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ifm_ready   = (state_q == ST_LOAD);
  assign bus.col_valid   = (state_q == ST_OUT);
  assign bus.lifm_column = col_q;
  assign bus.kidx        = kidx_q;
  assign bus.last_kidx   = (state_q == ST_OUT) && last_k;
  assign bus.last_tile   = (state_q == ST_OUT) && last_t;
  assign done            = done_q;
  assign cfg_error       = err_q;
endmodule
